// File: rtl/regfile_mp_pkg.sv
// Shared types and sizing helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;

    function automatic int depth_of(input int addr_w);
        return 2 ** addr_w;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback side bus of the register file: write, lock, clear and packed read ports.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 3
);
    logic                     clear_req;
    logic                     ready;
    logic                     we;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        wdata;
    logic                     lock_en;
    logic [ADDR_W-1:0]        lock_addr;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rpend;

    modport master (
        output clear_req, we, waddr, wdata, lock_en, lock_addr, raddr,
        input  ready, rdata, rpend
    );

    modport slave (
        input  clear_req, we, waddr, wdata, lock_en, lock_addr, raddr,
        output ready, rdata, rpend
    );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Per-register pending bits: set by a lock, cleared by a write or a clear, looked up per read port.
module regfile_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic                     lock_en,
    input  logic [ADDR_W-1:0]        lock_addr,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD-1:0]        rpend
);
    import regfile_pkg::*;

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DEPTH-1:0] pend_q;

    // Lock is applied after the write so a same-address lock leaves the bit set.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pend_q <= '0;
        end else begin
            if (we)      pend_q[waddr]     <= 1'b0;
            if (lock_en) pend_q[lock_addr] <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        assign rpend[i] = pend_q[raddr[i*ADDR_W +: ADDR_W]];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with clear sweep, optional write-to-read bypass and pending scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int                 DATA_W   = 32,
    parameter int                 ADDR_W   = DEF_ADDR_W,
    parameter int                 NUM_RD   = 3,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0,
    parameter int                 BYPASS   = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = depth_of(ADDR_W);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                active, clr, wr_en, lk_en;
    logic [NUM_RD-1:0]   pend_rd;

    assign active = (state_q == READY);
    assign clr    = active & bus.clear_req;
    assign wr_en  = active & bus.we      & ~bus.clear_req;
    assign lk_en  = active & bus.lock_en & ~bus.clear_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = READY;
            end
            READY: begin
                if (bus.clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Data array has no reset; the sweep owns the write port while in CLEAR.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) mem[cnt_q]     <= INIT_VAL;
            else if (wr_en)       mem[bus.waddr] <= bus.wdata;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .we        (wr_en),
        .waddr     (bus.waddr),
        .lock_en   (lk_en),
        .lock_addr (bus.lock_addr),
        .raddr     (bus.raddr),
        .rpend     (pend_rd)
    );

    assign bus.ready = active;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit;
        logic              lock_same;
        assign ra        = bus.raddr[i*ADDR_W +: ADDR_W];
        assign hit       = (BYPASS != 0) && bus.we && (bus.waddr == ra);
        assign lock_same = bus.lock_en && (bus.lock_addr == bus.waddr);
        assign bus.rdata[i*DATA_W +: DATA_W] = !active ? '0 : (hit ? bus.wdata : mem[ra]);
        assign bus.rpend[i] = active && (hit ? lock_same : pend_rd[i]);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed check of regfile_mp (bypass and non-bypass builds) against an array model.
module tb_regfile_mp;
    localparam int          DW     = 32;
    localparam int          AW     = 5;
    localparam int          NR     = 3;
    localparam int          D      = 32;
    localparam logic [31:0] INIT_B = 32'h5A5A_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) ifa ();
    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) ifb ();

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .INIT_VAL(32'h0), .BYPASS(1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .INIT_VAL(INIT_B), .BYPASS(0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    logic        s_we, s_lk, s_clr;
    logic [4:0]  s_wa, s_la;
    logic [31:0] s_wd;
    logic [4:0]  s_ra0, s_ra1, s_ra2;

    assign ifa.we = s_we;   assign ifb.we = s_we;
    assign ifa.waddr = s_wa; assign ifb.waddr = s_wa;
    assign ifa.wdata = s_wd; assign ifb.wdata = s_wd;
    assign ifa.lock_en = s_lk; assign ifb.lock_en = s_lk;
    assign ifa.lock_addr = s_la; assign ifb.lock_addr = s_la;
    assign ifa.clear_req = s_clr; assign ifb.clear_req = s_clr;
    assign ifa.raddr = {s_ra2, s_ra1, s_ra0};
    assign ifb.raddr = {s_ra2, s_ra1, s_ra0};

    // Reference model: architectural contents, pending flags and sweep progress.
    logic [31:0] ma [D];
    logic [31:0] mb [D];
    bit          mp [D];
    bit          m_rdy;
    int          sweep_left;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [4:0]  ra [NR];
        logic [31:0] ea, eb;
        bit          pa, pb, hit;
        ra[0] = s_ra0; ra[1] = s_ra1; ra[2] = s_ra2;
        chk("ready_a", ifa.ready, m_rdy);
        chk("ready_b", ifb.ready, m_rdy);
        for (int i = 0; i < NR; i++) begin
            ea = '0; eb = '0; pa = 0; pb = 0;
            if (m_rdy) begin
                hit = s_we && (s_wa == ra[i]);
                ea  = hit ? s_wd : ma[ra[i]];
                pa  = hit ? (s_lk && s_la == s_wa) : mp[ra[i]];
                eb  = mb[ra[i]];
                pb  = mp[ra[i]];
            end
            chk($sformatf("rdata_a%0d r%0d", i, ra[i]), ifa.rdata[i*DW +: DW], ea);
            chk($sformatf("rpend_a%0d r%0d", i, ra[i]), ifa.rpend[i], pa);
            chk($sformatf("rdata_b%0d r%0d", i, ra[i]), ifb.rdata[i*DW +: DW], eb);
            chk($sformatf("rpend_b%0d r%0d", i, ra[i]), ifb.rpend[i], pb);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_rdy = 0; sweep_left = D;
            for (int i = 0; i < D; i++) mp[i] = 0;
        end else if (!m_rdy) begin
            sweep_left--;
            if (sweep_left == 0) begin
                m_rdy = 1;
                for (int i = 0; i < D; i++) begin ma[i] = '0; mb[i] = INIT_B; end
            end
        end else if (s_clr) begin
            m_rdy = 0; sweep_left = D;
            for (int i = 0; i < D; i++) mp[i] = 0;
        end else begin
            if (s_we) begin ma[s_wa] = s_wd; mb[s_wa] = s_wd; mp[s_wa] = 0; end
            if (s_lk) mp[s_la] = 1;
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic lk, input logic [4:0] la, input logic clr,
                        input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
        s_we = we; s_wa = wa; s_wd = wd; s_lk = lk; s_la = la; s_clr = clr;
        s_ra0 = r0; s_ra1 = r1; s_ra2 = r2;
        #1 check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, r0, r1, r2);
    endtask

    // Counts edges until ready rises, optionally attempting writes to r5 meanwhile.
    task automatic wait_ready(input string tag, input logic try_we);
        int n = 0;
        while (n < 40) begin
            step(try_we, 5'd5, $urandom, 0, 0, 0, 5'd0, 5'd15, 5'd31);
            n++;
            if (ifa.ready === 1'b1) break;
        end
        chk(tag, n, 32);
    endtask

    initial begin
        logic [4:0] wa, la;
        s_we = 0; s_lk = 0; s_clr = 0; s_wa = 0; s_la = 0; s_wd = 0;
        s_ra0 = 0; s_ra1 = 0; s_ra2 = 0;
        m_rdy = 0; sweep_left = D;
        for (int i = 0; i < D; i++) mp[i] = 0;
        @(negedge clk);
        rst = 1;
        idle(2, 0, 15, 31);
        rst = 0;
        wait_ready("ready_latency", 0);
        idle(1, 0, 15, 31);

        step(1, 9, 32'h20, 0, 0, 0, 9, 9, 9);
        idle(1, 9, 9, 9);

        step(0, 0, 0, 1, 3, 0, 3, 3, 3);
        idle(3, 3, 3, 3);
        step(1, 3, 32'hDEADBEEF, 0, 0, 0, 3, 3, 3);
        idle(1, 3, 3, 3);

        step(1, 7, 32'h1234_5678, 1, 7, 0, 7, 7, 7);
        idle(1, 7, 7, 7);
        step(1, 2, 32'hCAFE_0002, 1, 1, 0, 1, 2, 7);
        idle(1, 1, 2, 7);

        rst = 1; idle(1, 0, 5, 31); rst = 0;
        for (int k = 0; k < 10; k++) step(1, 5, $urandom, 1, 5, 0, 5, 5, 5);
        rst = 1; idle(1, 0, 5, 31); rst = 0;
        wait_ready("ready_after_midsweep_rst", 1);
        idle(1, 5, 5, 5);

        for (int i = 0; i < D; i++) step(1, 5'(i), 32'(i), 0, 0, 0, 5'(i), 5'(i), 5'(i));
        step(0, 0, 0, 1, 4, 0, 4, 4, 4);
        idle(1, 0, 4, 31);
        step(1, 6, 32'hFF, 1, 8, 1, 4, 6, 8);
        wait_ready("ready_after_clear", 0);
        for (int i = 0; i < D; i++) idle(1, 5'(i), 5'((i + 1) % D), 5'((i + 7) % D));

        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 499) == 0);
            wa  = 5'($urandom_range(0, 31));
            la  = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 31));
            step($urandom_range(0, 1) == 1, wa, $urandom,
                 $urandom_range(0, 2) == 0, la, $urandom_range(0, 199) == 0,
                 ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 1) == 0) ? la : 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)));
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
